zoom_engine: RTL and testbench

- Execution side of the control unit's command path. Accepts a decoded command {ch, x, y}, runs one scaling operation from the source image memory into the destination frame buffer, then returns zoom_done.
- The control unit holds in its execute state until zoom_done arrives.
- Iterates over every destination pixel. Each pixel costs either one or four source reads plus one destination write.

---
 rtl/zoom_engine.sv | 159 +++++++++++++++
 tb/tb_zoom_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_engine.sv
// Scaling engine: walks every destination pixel and fetches one or four
// source samples for it. Then it writes the copied, zoomed, decimated or
// block-averaged result into the destination frame buffer.
module zoom_engine #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int DST_W  = 320,
  parameter int DST_H  = 240,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        ch,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic              busy,
  output logic              zoom_done,
  output logic              err,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WRITE, S_AREAD, S_AWRITE, S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        ch_q;
  logic [11:0]       x_q, y_q;
  logic [11:0]       i_q, j_q;
  logic [1:0]        sub_q;
  logic [PIX_W+1:0]  acc_q;
  logic              vld_p1;
  logic              err_q;

  logic [11:0]       sx, sy;
  logic              in_range;
  logic [PIX_W-1:0]  sample;
  logic [PIX_W+1:0]  sum;
  logic              last_col, last_row;
  logic [11:0]       i_nxt, j_nxt;

  // Source coordinate of the current destination pixel / sub-sample.
  always_comb begin
    sx = '0;
    sy = '0;
    case (ch_q)
      3'b000:  begin sx = x_q + i_q;        sy = y_q + j_q;        end
      3'b001:  begin sx = x_q + (i_q >> 1); sy = y_q + (j_q >> 1); end
      3'b010:  begin sx = x_q + (i_q >> 2); sy = y_q + (j_q >> 2); end
      3'b011:  begin sx = x_q + (i_q << 1); sy = y_q + (j_q << 1); end
      3'b100:  begin
        sx = x_q + (i_q << 1) + {11'b0, sub_q[0]};
        sy = y_q + (j_q << 1) + {11'b0, sub_q[1]};
      end
      default: begin sx = '0; sy = '0; end
    endcase
  end

  // Strobes and buses, decoded from state and registered counters only.
  always_comb begin
    in_range = (sx < 12'(SRC_W)) && (sy < 12'(SRC_H));
    src_rd   = ((state == S_ISSUE) || (state == S_AREAD)) && in_range;
    src_addr = src_rd ? (ADDR_W'(sy) * ADDR_W'(SRC_W) + ADDR_W'(sx)) : '0;
    // A sample that was never read (out of range) contributes zero.
    sample   = vld_p1 ? src_data : '0;
    sum      = acc_q + {2'b00, sample};
    dst_we   = (state == S_WRITE) || (state == S_AWRITE);
    dst_addr = dst_we ? (ADDR_W'(j_q) * ADDR_W'(DST_W) + ADDR_W'(i_q)) : '0;
    if (state == S_WRITE)
      dst_data = sample;
    else if (state == S_AWRITE)
      dst_data = sum[PIX_W+1:2];
    else
      dst_data = '0;
    busy      = (state != S_IDLE) && (state != S_DONE);
    zoom_done = (state == S_DONE);
    err       = (state == S_DONE) && err_q;
  end

  // Raster-order advance of the destination pixel counters.
  always_comb begin
    last_col = (i_q == 12'(DST_W - 1));
    last_row = (j_q == 12'(DST_H - 1));
    i_nxt    = last_col ? 12'd0 : i_q + 12'd1;
    if (!last_col)
      j_nxt = j_q;
    else if (last_row)
      j_nxt = 12'd0;
    else
      j_nxt = j_q + 12'd1;
  end

  // Command FSM, counters and the block-average accumulator.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      ch_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      sub_q  <= '0;
      acc_q  <= '0;
      vld_p1 <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe.
      vld_p1 <= src_rd;
      case (state)
        S_IDLE: begin
          if (start) begin
            ch_q  <= ch;
            x_q   <= {2'b00, x};
            y_q   <= {2'b00, y};
            i_q   <= '0;
            j_q   <= '0;
            sub_q <= '0;
            acc_q <= '0;
            if (ch > 3'b100) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q <= 1'b0;
              state <= (ch == 3'b100) ? S_AREAD : S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_WRITE;
        S_WRITE: begin
          i_q   <= i_nxt;
          j_q   <= j_nxt;
          state <= (last_col && last_row) ? S_DONE : S_ISSUE;
        end
        S_AREAD: begin
          sub_q <= sub_q + 2'd1;
          // Sub-sample 0 starts a fresh sum; later ones add the previous sample.
          acc_q <= (sub_q == 2'd0) ? '0 : sum;
          if (sub_q == 2'd3)
            state <= S_AWRITE;
        end
        S_AWRITE: begin
          i_q   <= i_nxt;
          j_q   <= j_nxt;
          state <= (last_col && last_row) ? S_DONE : S_AREAD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_engine.sv
// Directed bench for zoom_engine on a tiny 8x8 source and a 4x2 destination.
// The source memory returns data equal to its address.
module tb_zoom_engine;

  localparam int SRC_W  = 8;
  localparam int SRC_H  = 8;
  localparam int DST_W  = 4;
  localparam int DST_H  = 2;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 17;

  logic              clock;
  logic              reset;
  logic              start;
  logic [2:0]        ch;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              busy;
  logic              zoom_done;
  logic              err;
  logic              src_rd;
  logic [ADDR_W-1:0] src_addr;
  logic [PIX_W-1:0]  src_data;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [PIX_W-1:0]  dst_data;

  int tests;
  int fails;

  // Observations of the most recent command
  int dst_val [0:7];
  int wr_cnt, rd_cnt, bad_addr, overlap;
  int done_cnt, done_cyc, err_at_done;
  int busy_cnt, busy_first, busy_last;

  zoom_engine #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
    .PIX_W(PIX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .ch(ch), .x(x), .y(y),
    .busy(busy), .zoom_done(zoom_done), .err(err),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Source memory: one-cycle read latency, data = address; filler otherwise.
  always @(posedge clock)
    src_data <= src_rd ? src_addr[7:0] : 8'hEE;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command with start in cycle 0, optionally a second start pulse
  // in cycle s2_at, and record what the DUT does for ncyc cycles.
  task automatic run_cmd(input logic [2:0] c_ch, input logic [9:0] c_x,
                         input logic [9:0] c_y, input int ncyc,
                         input int s2_at, input logic [2:0] s2_ch);
    for (int k = 0; k < 8; k++) dst_val[k] = -1;
    wr_cnt = 0; rd_cnt = 0; bad_addr = 0; overlap = 0;
    done_cnt = 0; done_cyc = -1; err_at_done = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    @(posedge clock); #1;
    start = 1'b1; ch = c_ch; x = c_x; y = c_y;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (dst_we) begin
        wr_cnt++;
        if (dst_addr < 8) dst_val[dst_addr] = int'(dst_data);
        else bad_addr++;
      end
      if (src_rd) rd_cnt++;
      if (src_rd && dst_we) overlap++;
      if (zoom_done) begin
        done_cnt++;
        done_cyc = c;
        err_at_done = int'(err);
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      @(posedge clock); #1;
      if (c + 1 == s2_at) begin
        start = 1'b1; ch = s2_ch; x = 10'd0; y = 10'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ch = '0; x = '0; y = '0;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if ({busy, zoom_done, err, src_rd, dst_we} !== 5'b0 ||
        src_addr !== '0 || dst_addr !== '0 || dst_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b we=%b sa=%0d da=%0d dd=%0d, want all 0",
               busy, zoom_done, err, src_rd, dst_we, src_addr, dst_addr, dst_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_copy();
    run_cmd(3'b000, 10'd1, 10'd2, 22, -1, 3'b000);
    tests++; if (dst_val[0] !== 17) begin fails++; $display("FAIL copy_dst0: got %0d want 17", dst_val[0]); end
    tests++; if (dst_val[3] !== 20) begin fails++; $display("FAIL copy_dst3: got %0d want 20", dst_val[3]); end
    tests++; if (dst_val[4] !== 25) begin fails++; $display("FAIL copy_dst4: got %0d want 25", dst_val[4]); end
    tests++; if (dst_val[7] !== 28) begin fails++; $display("FAIL copy_dst7: got %0d want 28", dst_val[7]); end
    tests++; if (wr_cnt !== 8 || bad_addr !== 0) begin fails++; $display("FAIL copy_writes: got %0d (bad %0d) want 8", wr_cnt, bad_addr); end
    tests++; if (done_cnt !== 1 || done_cyc !== 17) begin fails++; $display("FAIL copy_done: got count %0d cycle %0d want 1 at 17", done_cnt, done_cyc); end
    tests++; if (err_at_done !== 0) begin fails++; $display("FAIL copy_err: got %0d want 0", err_at_done); end
    tests++; if (busy_cnt !== 16 || busy_first !== 1 || busy_last !== 16) begin fails++; $display("FAIL copy_busy: got %0d cycles %0d..%0d want 16 cycles 1..16", busy_cnt, busy_first, busy_last); end
    tests++; if (overlap !== 0) begin fails++; $display("FAIL copy_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_zoom2();
    int exp_z [0:7] = '{0, 0, 1, 1, 0, 0, 1, 1};
    run_cmd(3'b001, 10'd0, 10'd0, 22, -1, 3'b000);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (dst_val[k] !== exp_z[k]) begin fails++; $display("FAIL zoom2_dst%0d: got %0d want %0d", k, dst_val[k], exp_z[k]); end
    end
    tests++; if (rd_cnt !== 8) begin fails++; $display("FAIL zoom2_reads: got %0d want 8", rd_cnt); end
    tests++; if (wr_cnt !== 8) begin fails++; $display("FAIL zoom2_writes: got %0d want 8", wr_cnt); end
  endtask

  task automatic test_average();
    int exp_a [0:7] = '{4, 6, 8, 10, 20, 22, 24, 26};
    run_cmd(3'b100, 10'd0, 10'd0, 46, -1, 3'b000);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (dst_val[k] !== exp_a[k]) begin fails++; $display("FAIL avg_dst%0d: got %0d want %0d", k, dst_val[k], exp_a[k]); end
    end
    tests++; if (done_cnt !== 1 || done_cyc !== 41) begin fails++; $display("FAIL avg_done: got count %0d cycle %0d want 1 at 41", done_cnt, done_cyc); end
    tests++; if (rd_cnt !== 32 || wr_cnt !== 8) begin fails++; $display("FAIL avg_counts: got rd %0d wr %0d want 32 / 8", rd_cnt, wr_cnt); end
    tests++; if (overlap !== 0) begin fails++; $display("FAIL avg_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_decimate_range();
    int exp_d [0:7] = '{4, 6, 0, 0, 20, 22, 0, 0};
    run_cmd(3'b011, 10'd4, 10'd0, 22, -1, 3'b000);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (dst_val[k] !== exp_d[k]) begin fails++; $display("FAIL dec_dst%0d: got %0d want %0d", k, dst_val[k], exp_d[k]); end
    end
    tests++; if (rd_cnt !== 4) begin fails++; $display("FAIL dec_reads: got %0d want 4", rd_cnt); end
    tests++; if (done_cyc !== 17) begin fails++; $display("FAIL dec_done: got cycle %0d want 17", done_cyc); end
  endtask

  task automatic test_invalid();
    run_cmd(3'b111, 10'd0, 10'd0, 8, 1, 3'b000);
    tests++; if (done_cnt !== 1 || done_cyc !== 1) begin fails++; $display("FAIL inv_done: got count %0d cycle %0d want 1 at 1", done_cnt, done_cyc); end
    tests++; if (err_at_done !== 1) begin fails++; $display("FAIL inv_err: got %0d want 1", err_at_done); end
    tests++; if (rd_cnt !== 0 || wr_cnt !== 0) begin fails++; $display("FAIL inv_traffic: got rd %0d wr %0d want 0 / 0", rd_cnt, wr_cnt); end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL inv_start_ignored: got busy cycles %0d want 0", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    run_cmd(3'b000, 10'd1, 10'd2, 22, 5, 3'b001);
    tests++; if (dst_val[0] !== 17 || dst_val[7] !== 28) begin fails++; $display("FAIL busy_start_data: got %0d,%0d want 17,28", dst_val[0], dst_val[7]); end
    tests++; if (done_cnt !== 1 || done_cyc !== 17 || wr_cnt !== 8) begin fails++; $display("FAIL busy_start_done: got count %0d cycle %0d wr %0d want 1 at 17, 8", done_cnt, done_cyc, wr_cnt); end
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    @(posedge clock); #1;
    start = 1'b1; ch = 3'b000; x = 10'd1; y = 10'd2;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    // now in cycle 6: second half of pixel 2
    tests++; if (dst_we !== 1'b1) begin fails++; $display("FAIL abort_pre: got dst_we=%b want 1", dst_we); end
    reset = 1'b0;
    #1;
    tests++;
    if ({busy, zoom_done, err, src_rd, dst_we} !== 5'b0 ||
        src_addr !== '0 || dst_addr !== '0 || dst_data !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got busy=%b done=%b err=%b rd=%b we=%b da=%0d dd=%0d want all 0",
               busy, zoom_done, err, src_rd, dst_we, dst_addr, dst_data);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (zoom_done || dst_we || src_rd || busy) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
    run_cmd(3'b000, 10'd1, 10'd2, 22, -1, 3'b000);
    tests++; if (dst_val[0] !== 17 || dst_val[4] !== 25) begin fails++; $display("FAIL abort_rerun_data: got %0d,%0d want 17,25", dst_val[0], dst_val[4]); end
    tests++; if (done_cnt !== 1 || done_cyc !== 17 || wr_cnt !== 8) begin fails++; $display("FAIL abort_rerun_done: got count %0d cycle %0d wr %0d want 1 at 17, 8", done_cnt, done_cyc, wr_cnt); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_copy();
    test_zoom2();
    test_average();
    test_decimate_range();
    test_invalid();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
